// File: rtl/body_draw_sequencer_pkg.sv
// rtl/body_draw_sequencer_pkg.sv - shared types, widths and defaults for the body draw sequencer
package body_draw_sequencer_pkg;

  localparam int COORD_W         = 10;
  localparam int LINE_W          = 6;
  localparam int COLOR_W         = 10;
  localparam int NUM_LINES_DEF   = 48;
  localparam int SETTLE_CYC_DEF  = 2;

  localparam logic [COLOR_W-1:0] DRAW_COLOR_DEF  = 10'h3FF;
  localparam logic [COLOR_W-1:0] ERASE_COLOR_DEF = 10'h000;

  // Frame sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_SETUP = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4,
    ST_NEXT  = 3'd5,
    ST_SWAP  = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  typedef enum logic {
    PASS_ERASE = 1'b0,
    PASS_DRAW  = 1'b1
  } pass_t;

  // Head, left-hand and right-hand centres in the order the LUT expects.
  typedef struct packed {
    logic [COORD_W-1:0] hcx;
    logic [COORD_W-1:0] hcy;
    logic [COORD_W-1:0] lcx;
    logic [COORD_W-1:0] lcy;
    logic [COORD_W-1:0] rcx;
    logic [COORD_W-1:0] rcy;
  } pose_t;

  function automatic logic is_last_line(input logic [LINE_W-1:0] cnt, input int num_lines);
    return cnt == LINE_W'(num_lines - 1);
  endfunction

endpackage

// File: rtl/body_draw_sequencer_if.sv
// rtl/body_draw_sequencer_if.sv - frame request, pose and drawer handshake bundle
interface body_draw_sequencer_if;
  import body_draw_sequencer_pkg::*;

  logic               iFrame_req;
  logic               iEnable;
  logic [COORD_W-1:0] iHcx;
  logic [COORD_W-1:0] iHcy;
  logic [COORD_W-1:0] iLcx;
  logic [COORD_W-1:0] iLcy;
  logic [COORD_W-1:0] iRcx;
  logic [COORD_W-1:0] iRcy;
  logic [COORD_W-1:0] oOldhcx;
  logic [COORD_W-1:0] oOldhcy;
  logic [COORD_W-1:0] oOldlcx;
  logic [COORD_W-1:0] oOldlcy;
  logic [COORD_W-1:0] oOldrcx;
  logic [COORD_W-1:0] oOldrcy;
  logic [LINE_W-1:0]  oLineCount;
  logic [COLOR_W-1:0] oColor;
  logic               oLine_start;
  logic               iLine_done;
  logic               oBusy;
  logic               oFrame_done;

  // Host side: frame source plus the line drawer.
  modport master (
    output iFrame_req, iEnable, iHcx, iHcy, iLcx, iLcy, iRcx, iRcy, iLine_done,
    input  oOldhcx, oOldhcy, oOldlcx, oOldlcy, oOldrcx, oOldrcy,
    input  oLineCount, oColor, oLine_start, oBusy, oFrame_done
  );

  // Sequencer side.
  modport slave (
    input  iFrame_req, iEnable, iHcx, iHcy, iLcx, iLcy, iRcx, iRcy, iLine_done,
    output oOldhcx, oOldhcy, oOldlcx, oOldlcy, oOldrcx, oOldrcy,
    output oLineCount, oColor, oLine_start, oBusy, oFrame_done
  );

endinterface

// File: rtl/body_draw_sequencer_settle.sv
// rtl/body_draw_sequencer_settle.sv - LUT settle delay counter (load, decrement, zero flag)
module body_draw_sequencer_settle #(
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  // Loaded with SETTLE_CYC-1 so that SETUP lasts exactly SETTLE_CYC cycles.
  localparam int              CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: reload wins over decrement; saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/body_draw_sequencer.sv
// rtl/body_draw_sequencer.sv - per-frame line sequencer for the body LUT and line drawer (option: BODY_SEQ_ERASE_EN)
module body_draw_sequencer
  import body_draw_sequencer_pkg::*;
#(
  parameter int                 NUM_LINES   = NUM_LINES_DEF,
  parameter int                 SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter logic [COLOR_W-1:0] DRAW_COLOR  = DRAW_COLOR_DEF,
  parameter logic [COLOR_W-1:0] ERASE_COLOR = ERASE_COLOR_DEF
) (
  input logic                  iCLK,
  input logic                  iRST_N,
  body_draw_sequencer_if.slave bus
);

  state_t             state_q, state_d;
  pose_t              old_pose_q, old_pose_d;
  logic [LINE_W-1:0]  line_cnt_q, line_cnt_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               line_start_q, line_start_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;

  logic               settle_load;
  logic               settle_dec;
  logic               settle_zero;
  pose_t              in_pose;

`ifdef BODY_SEQ_ERASE_EN
  // The new pose is held aside until the old figure is fully erased.
  pose_t              new_pose_q, new_pose_d;
  pass_t              pass_q, pass_d;
`endif

  assign in_pose = {bus.iHcx, bus.iHcy, bus.iLcx, bus.iLcy, bus.iRcx, bus.iRcy};

  body_draw_sequencer_settle #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settle (
    .clk   (iCLK),
    .rst_n (iRST_N),
    .load  (settle_load),
    .dec   (settle_dec),
    .zero  (settle_zero)
  );

  // Next-state and registered-output decode for the frame sequencer.
  always_comb begin
    state_d      = state_q;
    old_pose_d   = old_pose_q;
    line_cnt_d   = line_cnt_q;
    color_d      = color_q;
    busy_d       = busy_q;
    line_start_d = 1'b0;
    frame_done_d = 1'b0;
    settle_load  = 1'b0;
    settle_dec   = 1'b0;
`ifdef BODY_SEQ_ERASE_EN
    new_pose_d   = new_pose_q;
    pass_d       = pass_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // Only IDLE accepts requests; anything arriving while busy is dropped.
        if (bus.iFrame_req && bus.iEnable) begin
          state_d = ST_LATCH;
          busy_d  = 1'b1;
        end
      end

      ST_LATCH: begin
        line_cnt_d  = '0;
        settle_load = 1'b1;
        state_d     = ST_SETUP;
`ifdef BODY_SEQ_ERASE_EN
        // LUT keeps seeing the old pose so the erase pass hits the drawn figure.
        new_pose_d  = in_pose;
        pass_d      = PASS_ERASE;
        color_d     = ERASE_COLOR;
`else
        old_pose_d  = in_pose;
        color_d     = DRAW_COLOR;
`endif
      end

      ST_SETUP: begin
        if (settle_zero) begin
          state_d      = ST_START;
          line_start_d = 1'b1;
        end else begin
          settle_dec = 1'b1;
        end
      end

      ST_START: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // Done may already be high if the drawer was idle; take it immediately.
        if (bus.iLine_done) begin
          state_d = ST_NEXT;
        end
      end

      ST_NEXT: begin
        if (is_last_line(line_cnt_q, NUM_LINES)) begin
`ifdef BODY_SEQ_ERASE_EN
          if (pass_q == PASS_ERASE) begin
            state_d = ST_SWAP;
          end else begin
            state_d      = ST_DONE;
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            color_d      = ERASE_COLOR;
          end
`else
          state_d      = ST_DONE;
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          color_d      = ERASE_COLOR;
`endif
        end else begin
          line_cnt_d  = line_cnt_q + LINE_W'(1);
          settle_load = 1'b1;
          state_d     = ST_SETUP;
        end
      end

`ifdef BODY_SEQ_ERASE_EN
      ST_SWAP: begin
        old_pose_d  = new_pose_q;
        line_cnt_d  = '0;
        pass_d      = PASS_DRAW;
        color_d     = DRAW_COLOR;
        settle_load = 1'b1;
        state_d     = ST_SETUP;
      end
`endif

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and output registers; reset aborts any frame in flight.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= ST_IDLE;
      old_pose_q   <= '0;
      line_cnt_q   <= '0;
      color_q      <= ERASE_COLOR;
      line_start_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      old_pose_q   <= old_pose_d;
      line_cnt_q   <= line_cnt_d;
      color_q      <= color_d;
      line_start_q <= line_start_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef BODY_SEQ_ERASE_EN
  // Shadow pose and pass tracking for the erase-then-draw sequence.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      new_pose_q <= '0;
      pass_q     <= PASS_ERASE;
    end else begin
      new_pose_q <= new_pose_d;
      pass_q     <= pass_d;
    end
  end
`endif

  assign bus.oOldhcx     = old_pose_q.hcx;
  assign bus.oOldhcy     = old_pose_q.hcy;
  assign bus.oOldlcx     = old_pose_q.lcx;
  assign bus.oOldlcy     = old_pose_q.lcy;
  assign bus.oOldrcx     = old_pose_q.rcx;
  assign bus.oOldrcy     = old_pose_q.rcy;
  assign bus.oLineCount  = line_cnt_q;
  assign bus.oColor      = color_q;
  assign bus.oLine_start = line_start_q;
  assign bus.oBusy       = busy_q;
  assign bus.oFrame_done = frame_done_q;

endmodule

// File: tb/tb_body_draw_sequencer.sv
// tb/tb_body_draw_sequencer.sv - self-checking bench for body_draw_sequencer (honours BODY_SEQ_ERASE_EN)
module tb_body_draw_sequencer;

  localparam int        N       = 48;
  localparam int        S       = 2;
  localparam logic [9:0] DRAW_C  = 10'h3FF;
  localparam logic [9:0] ERASE_C = 10'h000;
`ifdef BODY_SEQ_ERASE_EN
  localparam bit        ERASE_EN = 1'b1;
`else
  localparam bit        ERASE_EN = 1'b0;
`endif
  localparam int        PASSES   = ERASE_EN ? 2 : 1;

  typedef struct packed {
    logic [9:0] hcx, hcy, lcx, lcy, rcx, rcy;
  } tpose_t;

  typedef struct packed {
    logic [5:0] line;
    logic [9:0] color;
    tpose_t     pose;
  } rec_t;

  typedef struct {
    tpose_t pose;
    int     lat;
    bit     noise;
    int     exp_starts;
    int     exp_cycles;
  } vec_t;

  localparam logic [127:0] RESET_VEC = 128'({60'd0, 6'd0, ERASE_C, 3'b000});

  logic   iCLK   = 1'b0;
  logic   iRST_N = 1'b0;
  int     total  = 0;
  int     bad    = 0;
  int     drv_lat  = 0;
  int     done_cnt = 0;
  rec_t   rec_q[$];
  rec_t   exp_q[$];
  tpose_t model_old = '0;

  body_draw_sequencer_if bus ();

  body_draw_sequencer #(
    .NUM_LINES   (N),
    .SETTLE_CYC  (S),
    .DRAW_COLOR  (DRAW_C),
    .ERASE_COLOR (ERASE_C)
  ) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .bus    (bus)
  );

  always #5 iCLK = ~iCLK;

  function automatic tpose_t mk_pose(input int a, input int b, input int c,
                                     input int d, input int e, input int f);
    return {10'(a), 10'(b), 10'(c), 10'(d), 10'(e), 10'(f)};
  endfunction

  function automatic tpose_t rnd_pose();
    return mk_pose($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
                   $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
  endfunction

  function automatic tpose_t bus_pose();
    return {bus.oOldhcx, bus.oOldhcy, bus.oOldlcx, bus.oOldlcy, bus.oOldrcx, bus.oOldrcy};
  endfunction

  function automatic logic [127:0] out_vec();
    return 128'({bus_pose(), bus.oLineCount, bus.oColor, bus.oLine_start, bus.oBusy, bus.oFrame_done});
  endfunction

  // Frame length from LATCH to DONE inclusive: per line settle + start + wait + next.
  function automatic int frame_cycles(input int lat);
    int wait_c;
    wait_c = (lat < 1) ? 1 : lat;
    return 2 + PASSES * N * (S + 2 + wait_c) + (ERASE_EN ? 1 : 0);
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic set_pose(input tpose_t p);
    {bus.iHcx, bus.iHcy, bus.iLcx, bus.iLcy, bus.iRcx, bus.iRcy} = p;
  endtask

  // Reference: list of (line, colour, pose) the drawer should be started with.
  task automatic model_frame(input tpose_t p);
    rec_t r;
    exp_q.delete();
    if (ERASE_EN) begin
      for (int l = 0; l < N; l++) begin
        r.line = 6'(l); r.color = ERASE_C; r.pose = model_old;
        exp_q.push_back(r);
      end
    end
    for (int l = 0; l < N; l++) begin
      r.line = 6'(l); r.color = DRAW_C; r.pose = p;
      exp_q.push_back(r);
    end
    model_old = p;
  endtask

  task automatic do_frame(input string nm, input tpose_t p, input int lat, input bit noise,
                          input int exp_starts, input int exp_cycles);
    int cycles;
    bit got_done;
    drv_lat = lat;
    @(posedge iCLK);
    rec_q.delete();
    done_cnt = 0;
    @(negedge iCLK);
    set_pose(p);
    bus.iEnable    = 1'b1;
    bus.iFrame_req = 1'b1;
    @(negedge iCLK);
    bus.iFrame_req = 1'b0;
    if (noise) bus.iEnable = 1'b0;
    cycles   = 1;
    got_done = 1'b0;
    for (int k = 0; k < 20000 && !got_done; k++) begin
      @(negedge iCLK);
      cycles++;
      if (bus.oFrame_done) begin
        got_done = 1'b1;
      end else if (noise) begin
        bus.iFrame_req = bus.oBusy & ($urandom_range(0, 7) == 0);
        set_pose(rnd_pose());
      end
    end
    bus.iFrame_req = 1'b0;
    bus.iEnable    = 1'b1;
    chk({nm, " frame_done_seen"}, 128'(got_done), 128'(1));
    chk({nm, " frame_cycles"}, 128'(cycles), 128'(exp_cycles));
    model_frame(p);
    repeat (4) @(negedge iCLK);
    chk({nm, " idle_busy"}, 128'(bus.oBusy), 128'(0));
    chk({nm, " done_pulses"}, 128'(done_cnt), 128'(1));
    chk({nm, " starts"}, 128'(rec_q.size()), 128'(exp_starts));
    for (int i = 0; i < exp_q.size() && i < rec_q.size(); i++) begin
      chk($sformatf("%s line%0d", nm, i), 128'(rec_q[i]), 128'(exp_q[i]));
    end
  endtask

  // Line drawer stand-in: done drops on start and returns drv_lat cycles later.
  initial begin
    int dcnt;
    dcnt = 0;
    bus.iLine_done = 1'b0;
    forever begin
      @(negedge iCLK);
      if (bus.oLine_start) dcnt = drv_lat;
      else if (dcnt > 0) dcnt--;
      bus.iLine_done = (dcnt == 0);
    end
  end

  // Monitor: record every start pulse with the LUT inputs it was issued against.
  initial begin
    rec_t r;
    forever begin
      @(negedge iCLK);
      if (bus.oLine_start) begin
        r.line  = bus.oLineCount;
        r.color = bus.oColor;
        r.pose  = bus_pose();
        rec_q.push_back(r);
      end
      if (bus.oFrame_done) done_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t   vecs[4];
    bit     found;
    tpose_t p;
    int     lat;

    vecs[0] = '{mk_pose(320, 100, 300, 150, 340, 150), 3, 1'b0, PASSES * N, frame_cycles(3)};
    vecs[1] = '{mk_pose(330, 100, 310, 150, 350, 150), 0, 1'b0, PASSES * N, frame_cycles(0)};
    vecs[2] = '{mk_pose(1023, 0, 5, 1023, 512, 777),   1, 1'b1, PASSES * N, frame_cycles(1)};
    vecs[3] = '{mk_pose(17, 900, 64, 32, 1000, 2),     5, 1'b1, PASSES * N, frame_cycles(5)};

    bus.iFrame_req = 1'b0;
    bus.iEnable    = 1'b0;
    set_pose('0);

    repeat (3) @(negedge iCLK);
    chk("reset_outputs", out_vec(), RESET_VEC);
    iRST_N = 1'b1;
    repeat (2) @(negedge iCLK);
    chk("idle_after_reset", out_vec(), RESET_VEC);

    // Request with enable low must not start a frame.
    @(posedge iCLK);
    rec_q.delete();
    @(negedge iCLK);
    set_pose(mk_pose(1, 2, 3, 4, 5, 6));
    bus.iFrame_req = 1'b1;
    @(negedge iCLK);
    bus.iFrame_req = 1'b0;
    repeat (3) @(negedge iCLK);
    chk("enable_low_busy", 128'(bus.oBusy), 128'(0));
    chk("enable_low_starts", 128'(rec_q.size()), 128'(0));

    for (int v = 0; v < 4; v++) begin
      do_frame($sformatf("vec%0d", v), vecs[v].pose, vecs[v].lat, vecs[v].noise,
               vecs[v].exp_starts, vecs[v].exp_cycles);
      if (v == 1) begin
        if (rec_q.size() > 0) begin
          chk("f2_first_hcx", 128'(rec_q[0].pose.hcx), 128'(ERASE_EN ? 320 : 330));
          chk("f2_first_color", 128'(rec_q[0].color), 128'(ERASE_EN ? ERASE_C : DRAW_C));
          chk("f2_last_hcx", 128'(rec_q[rec_q.size() - 1].pose.hcx), 128'(330));
          chk("f2_last_color", 128'(rec_q[rec_q.size() - 1].color), 128'(DRAW_C));
        end else begin
          chk("f2_records", 128'(0), 128'(1));
        end
      end
    end

    for (int r = 0; r < 4; r++) begin
      p   = rnd_pose();
      lat = $urandom_range(0, 4);
      do_frame($sformatf("rnd%0d", r), p, lat, 1'b1, PASSES * N, frame_cycles(lat));
    end

    // Reset during line 20 of the draw pass.
    drv_lat = 2;
    @(posedge iCLK);
    rec_q.delete();
    @(negedge iCLK);
    set_pose(mk_pose(600, 400, 580, 420, 620, 420));
    bus.iEnable    = 1'b1;
    bus.iFrame_req = 1'b1;
    @(negedge iCLK);
    bus.iFrame_req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20000 && !found; k++) begin
      @(negedge iCLK);
      if (bus.oLine_start && bus.oLineCount == 6'd20 && bus.oColor == DRAW_C) found = 1'b1;
    end
    chk("rst_mid_reach_line20", 128'(found), 128'(1));
    @(negedge iCLK);
    #2 iRST_N = 1'b0;
    #1 chk("rst_mid_outputs", out_vec(), RESET_VEC);
    @(negedge iCLK);
    iRST_N    = 1'b1;
    model_old = '0;
    do_frame("after_rst", mk_pose(100, 200, 80, 220, 120, 220), 1, 1'b0, PASSES * N, frame_cycles(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
